// File: rtl/mac_job_sched.sv
// Two-requester round-robin job scheduler for the 4-lane MAC unit.
// Walks the operand BRAM one word per MAC operation and sums the per-word
// results into a wide accumulator; one result is returned per job.
module mac_job_sched #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8,
  parameter int RES_W  = 32,
  parameter int ACC_W  = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*LEN_W-1:0]    req_len,
  output logic [1:0]            req_ready,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  mac_start,
  input  logic                  mac_done,
  input  logic [RES_W-1:0]      mac_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res_data,
  output logic                  res_id,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_START,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                rr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    remaining;
  logic [ACC_W-1:0]    acc;
  logic                id;
  logic [1:0]          grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;

  // Round-robin arbitration; the pointer only matters when both requesters are pending.
  // Grant is gated by rst so no handshake completes while reset is held.
  always_comb begin
    grant = '0;
    if (state == S_IDLE && !rst) begin
      if (req_valid[0] && (!req_valid[1] || !rr))
        grant = 2'b01;
      else if (req_valid[1])
        grant = 2'b10;
    end
    sel_addr = grant[1] ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    sel_len  = grant[1] ? req_len[LEN_W +: LEN_W]    : req_len[0 +: LEN_W];
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant != '0) state_nxt = (sel_len == '0) ? S_DONE : S_ADDR;
      S_ADDR:  state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (mac_done) state_nxt = S_ACC;
      S_ACC:   state_nxt = (remaining == '0) ? S_DONE : S_ADDR;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Job context and accumulator; the MAC result is summed on the edge that
  // samples mac_done so ACC only has to decide between next word and finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      acc       <= '0;
      id        <= 1'b0;
    end else begin
      if (grant != '0) begin
        cur_addr  <= sel_addr;
        remaining <= sel_len;
        id        <= grant[1];
        acc       <= '0;
        if (&req_valid) rr <= grant[0];
      end
      if (state == S_WAIT && mac_done) begin
        acc       <= acc + ACC_W'(mac_result);
        remaining <= remaining - LEN_W'(1);
      end
      if (state == S_ACC && remaining != '0)
        cur_addr <= cur_addr + ADDR_W'(1);
    end
  end

  assign req_ready = grant;
  assign bram_addr = cur_addr;
  assign mac_start = (state == S_START);
  assign res_valid = (state == S_DONE);
  assign res_data  = acc;
  assign res_id    = id;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mac_job_sched.sv
// Directed bench for mac_job_sched with a BRAM model and a MAC model whose
// done rises 3 cycles after start.
module tb_mac_job_sched;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 8;
  localparam int RES_W  = 32;
  localparam int ACC_W  = 48;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*LEN_W-1:0]  req_len;
  logic [1:0]          req_ready;
  logic [ADDR_W-1:0]   bram_addr;
  logic                mac_start;
  logic                mac_done = 1'b0;
  logic [RES_W-1:0]    mac_result = '0;
  logic                res_valid;
  logic                res_ready;
  logic [ACC_W-1:0]    res_data;
  logic                res_id;
  logic                busy;

  always #5 clk = ~clk;

  mac_job_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RES_W(RES_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .bram_addr(bram_addr), .mac_start(mac_start), .mac_done(mac_done), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  // Operand BRAMs with 1-cycle read latency.
  logic [63:0] mem_a [512];
  logic [63:0] mem_b [512];
  logic [63:0] a_q, b_q;
  always @(posedge clk) begin
    a_q <= mem_a[bram_addr];
    b_q <= mem_b[bram_addr];
  end

  function automatic logic [31:0] dot(input logic [63:0] a, input logic [63:0] b);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s += 32'(a[16*i +: 16]) * 32'(b[16*i +: 16]);
    return s;
  endfunction

  // MAC model: done level rises 3 cycles after start and stays until next start.
  logic ff_mode = 1'b0;
  int   mcnt = 0;
  always @(posedge clk) begin
    if (mac_start) begin
      mcnt       <= 2;
      mac_done   <= 1'b0;
      mac_result <= ff_mode ? 32'hFFFF_FFFF : dot(a_q, b_q);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mac_done <= 1'b1;
    end
  end

  // Cycle counter and observation of starts / result-valid cycles.
  int cyc = 0;
  int nstart = 0;
  int nres = 0;
  logic [ADDR_W-1:0] start_addr[$];
  int start_cyc[$];
  always @(posedge clk) begin
    if (mac_start) begin
      start_addr.push_back(bram_addr);
      start_cyc.push_back(cyc);
      nstart++;
    end
    if (res_valid) nres++;
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_addr[n*ADDR_W +: ADDR_W] = a;
    req_len[n*LEN_W +: LEN_W]    = l;
    req_valid[n]                 = 1'b1;
  endtask

  // Returns at the negedge following the grant, with the granted request dropped.
  task automatic wait_grant(output logic [1:0] g, output int gc);
    g  = '0;
    gc = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready != '0) begin
        g  = req_ready;
        gc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = req_valid & ~g;
  endtask

  task automatic wait_valid(input int limit, output int rc);
    rc = -1;
    for (int i = 0; i < limit; i++) begin
      #1;
      if (res_valid) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Waits for a result, captures it, and accepts it.
  task automatic get_result(input int limit, output logic [ACC_W-1:0] d, output logic i, output int rc);
    wait_valid(limit, rc);
    d = (rc < 0) ? '1 : res_data;
    i = (rc < 0) ? 1'bx : res_id;
    accept();
  endtask

  logic [1:0]       g;
  int               gc, rc, n0, q0, r0;
  logic [ACC_W-1:0] d;
  logic             id;

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 64'h0004_0003_0002_0001;
    mem_b[0] = 64'h0005_0004_0003_0002;
    mem_a[1] = 64'h0001_0001_0001_0001;
    mem_b[1] = 64'h0001_0001_0001_0001;

    // Reset with a pending request: no grant may appear while rst is held.
    rst = 1'b1; req_valid = 2'b01; req_addr = '0; req_len = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);

    // Single word job from requester 0.
    n0 = nstart; q0 = start_addr.size();
    set_req(0, 9'd0, 8'd1);
    wait_grant(g, gc);
    chk("t1_grant", g, 2'b01);
    #1;
    chk("t1_busy", busy, 1);
    get_result(100, d, id, rc);
    chk("t1_data", d, 40);
    chk("t1_id", id, 0);
    chk("t1_nstart", nstart - n0, 1);
    chk("t1_start_lat", start_cyc[q0] - gc, 2);

    // Two word job from requester 1.
    n0 = nstart; q0 = start_addr.size();
    set_req(1, 9'd0, 8'd2);
    wait_grant(g, gc);
    chk("t2_grant", g, 2'b10);
    get_result(100, d, id, rc);
    chk("t2_data", d, 44);
    chk("t2_id", id, 1);
    chk("t2_nstart", nstart - n0, 2);
    chk("t2_addr0", start_addr[q0], 0);
    chk("t2_addr1", start_addr[q0+1], 1);
    chk("t2_word_gap", start_cyc[q0+1] - start_cyc[q0], 6);

    // Both pending: pointer starts at requester 0.
    set_req(0, 9'd0, 8'd1);
    set_req(1, 9'd0, 8'd1);
    wait_grant(g, gc);
    chk("t3a_grant0", g, 2'b01);
    get_result(100, d, id, rc);
    chk("t3a_data0", d, 40);
    chk("t3a_id0", id, 0);
    wait_grant(g, gc);
    chk("t3a_grant1", g, 2'b10);
    chk("t3a_no_grant_in_done", gc, rc + 1);
    get_result(100, d, id, rc);
    chk("t3a_id1", id, 1);

    // Both pending again: pointer now selects requester 1.
    set_req(0, 9'd0, 8'd1);
    set_req(1, 9'd0, 8'd1);
    wait_grant(g, gc);
    chk("t3b_grant1", g, 2'b10);
    get_result(100, d, id, rc);
    chk("t3b_id1", id, 1);
    wait_grant(g, gc);
    chk("t3b_grant0", g, 2'b01);
    get_result(100, d, id, rc);
    chk("t3b_id0", id, 0);
    chk("t3b_data0", d, 40);

    // Zero-length job.
    n0 = nstart;
    set_req(0, 9'd5, 8'd0);
    wait_grant(g, gc);
    chk("t4_grant", g, 2'b01);
    get_result(100, d, id, rc);
    chk("t4_data", d, 0);
    chk("t4_valid_lat", rc - gc, 1);
    chk("t4_nstart", nstart - n0, 0);

    // Consumer stall with another request pending.
    set_req(1, 9'd0, 8'd1);
    wait_grant(g, gc);
    chk("t5_grant", g, 2'b10);
    set_req(0, 9'd0, 8'd1);
    wait_valid(100, rc);
    chk("t5_valid_seen", rc >= 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("t5_hold_valid", res_valid, 1);
      chk("t5_hold_data", res_data, 40);
      chk("t5_hold_ready", req_ready, 2'b00);
    end
    accept();
    wait_grant(g, gc);
    chk("t5_grant_after", g, 2'b01);
    get_result(100, d, id, rc);
    chk("t5_id_after", id, 0);

    // Long job with all-ones MAC results and address wrap.
    ff_mode = 1'b1;
    n0 = nstart; q0 = start_addr.size();
    set_req(0, 9'h1F0, 8'd255);
    wait_grant(g, gc);
    chk("t6_grant", g, 2'b01);
    get_result(4000, d, id, rc);
    chk("t6_data", d, 48'h00FE_FFFF_FF01);
    chk("t6_nstart", nstart - n0, 255);
    if (start_addr.size() >= q0 + 17) begin
      chk("t6_addr_1ff", start_addr[q0+15], 9'h1FF);
      chk("t6_addr_wrap", start_addr[q0+16], 9'h000);
    end else begin
      chk("t6_addr_count", start_addr.size() - q0, 255);
    end
    ff_mode = 1'b0;

    // Reset during WAIT of a len=4 job, with a request pending during reset.
    set_req(0, 9'd0, 8'd4);
    wait_grant(g, gc);
    chk("t7_grant", g, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 9'd0, 8'd1);
    r0 = nres;
    @(negedge clk);
    #1;
    chk("t7_req_ready", req_ready, 2'b00);
    chk("t7_bram_addr", bram_addr, 0);
    chk("t7_mac_start", mac_start, 0);
    chk("t7_res_valid", res_valid, 0);
    chk("t7_res_data", res_data, 0);
    chk("t7_res_id", res_id, 0);
    chk("t7_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;
    repeat (6) @(negedge clk);
    chk("t7_no_result", nres - r0, 0);
    n0 = nstart;
    set_req(0, 9'd0, 8'd1);
    wait_grant(g, gc);
    chk("t7_regrant", g, 2'b01);
    get_result(100, d, id, rc);
    chk("t7_data", d, 40);
    chk("t7_id", id, 0);
    chk("t7_nstart", nstart - n0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_job_sched.md
Name: mac_job_sched

Overview:
Two-requester job scheduler and sequencer for the 4-lane 16-bit MAC unit. It accepts dot-product jobs (base word address, length in 64-bit words) and arbitrates between requesters round-robin. For each word it walks the shared operand BRAM address, pulses the MAC start, and waits for the MAC done. Per-word MAC results are summed into a wide accumulator, and one result is returned per job with the requester ID.

Parameters:
ADDR_W, 9, operand BRAM word-address width
LEN_W, 8, job length width in 64-bit words (max 255)
RES_W, 32, MAC result width (2*DATA_WIDTH of the MAC)
ACC_W, 48, job accumulator width; must be >= RES_W+LEN_W

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester job request, level
req_addr  in  2*ADDR_W  base word address; requester n at [n*ADDR_W +: ADDR_W]
req_len  in  2*LEN_W  job length in words; requester n at [n*LEN_W +: LEN_W]
req_ready  out  2  one-hot one-cycle grant; the job is captured in that cycle
bram_addr  out  ADDR_W  read address to both operand BRAMs (A and B), 1-cycle read latency
mac_start  out  1  one-cycle start pulse to the MAC unit
mac_done  in  1  MAC status_done (level)
mac_result  in  RES_W  MAC result, valid while mac_done=1
res_valid  out  1  job result valid, held until accepted
res_ready  in  1  result consumer ready
res_data  out  ACC_W  job sum
res_id  out  1  requester that issued the job
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; req_ready=0, bram_addr=0, mac_start=0, res_valid=0, res_data=0, res_id=0, busy=0, rr pointer=0 (requester 0 has priority next).
- Reset asserted mid-job: abort at the next edge and emit no result. The bench must let any in-flight MAC finish before the next job.
- States: IDLE, ADDR, START, WAIT, ACC, DONE.
- IDLE: if any req_valid is set, grant one:
  - single requester: grant it;
  - both requesters: grant the requester the rr pointer selects, then rr pointer = other requester.
  - In the grant cycle: req_ready pulses, addr/len/id are captured, acc=0, next state ADDR. If len==0, next state is DONE instead (res_data=0, no MAC issued).
- ADDR: bram_addr=cur_addr; held stable through START and WAIT.
- START: BRAM data is valid; mac_start=1 for exactly this cycle; then WAIT.
- WAIT: stay until mac_done=1. mac_done is ignored in every other state.
- ACC: on the cycle mac_done is sampled, acc += zero-extended mac_result and remaining -= 1.
  - If remaining becomes 0, go to DONE.
  - Otherwise cur_addr += 1 (wraps mod 2^ADDR_W), go to ADDR.
- DONE: res_valid=1, res_data=acc, res_id=id. Hold until res_valid && res_ready, then go to IDLE with res_valid=0. No new grant in that same cycle.
- Timing: grant at cycle c → mac_start at c+2. With a mac_done arriving d cycles after mac_start, each following word's mac_start is d+3 cycles after the previous one.
- Accumulator arithmetic is unsigned; ACC_W sizing guarantees no overflow for a LEN_W-bit length.
- req_valid dropping while the job is busy has no effect on the job.

Test Plan:
- Bench uses a MAC model with done 3 cycles after start. Job from req0: addr=0, len=1, BRAM A[0]={4,3,2,1}, B[0]={5,4,3,2} → one mac_start, res_data=40, res_id=0, mac_start 2 cycles after req_ready.
- req1: addr=0, len=2, word1 A/B all ones → bram_addr sequence 0,1; res_data=44, res_id=1.
- Both req_valid high after reset → req0 granted first, req1 granted after req0's result is accepted. Repeat with both high → req1 granted first (rr pointer alternates).
- len=0 job → no mac_start, res_valid 1 cycle after grant with res_data=0.
- MAC model returns 32'hFFFF_FFFF per word, len=255, addr=9'h1F0 → bram_addr wraps 1FF→000; res_data=48'h00FE_FFFF_FF01.
- rst asserted during WAIT of a len=4 job → all outputs at reset values next cycle, no res_valid; a following len=1 job returns a correct result.
- res_ready held low 10 cycles → res_valid and res_data stable, req_ready stays 0 despite pending req_valid.
